// File: rtl/dsp_mac_sequencer.sv
// ============================================================================
// dsp_mac_sequencer
// ----------------------------------------------------------------------------
// Initiator-side controller for a DSP48A1 slice that computes signed dot
// products. Operand pairs arrive on a valid/ready stream. Each accepted beat
// is registered onto the slice A/B/D inputs. A {valid, first, last} tag
// follows the beat through a shadow of the slice register pipeline. The tag
// produces OPMODE and CEP at the correct stages and marks the cycle where the
// final sum appears on DSP_P. One 48-bit result per vector is returned on a
// valid/ready output stream.
//
// Optional build macro: SEQ_PREADD_EN
//   defined   : adds s_d_i; products become (s_d + s_b) * s_a
//   undefined : no s_d_i; DSP_D tied 0; products are s_a * s_b
//
// Ports
//   clk_i, rst_n_i         clock (rising edge), synchronous active-low reset
//   s_valid_i/s_ready_o    operand beat handshake
//   s_a_i, s_b_i           signed 18-bit operands
//   s_d_i                  signed 18-bit pre-adder operand (SEQ_PREADD_EN only)
//   s_last_i               final beat of the vector
//   m_valid_o/m_ready_i    result handshake
//   m_data_o               48-bit two's complement dot product
//   m_count_o              beats in the vector (saturating)
//   m_carry_o              sticky OR of DSP_CARRYOUT over the vector
//   DSP_*_o                slice operands, OPMODE, clock enables, resets
//   DSP_P_i, DSP_CARRYOUT_i  slice results
// ============================================================================
module dsp_mac_sequencer #(
    parameter int DSP_LAT = 4,
    parameter int OPM_DLY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [17:0]      s_a_i,
    input  logic [17:0]      s_b_i,
`ifdef SEQ_PREADD_EN
    input  logic [17:0]      s_d_i,
`endif
    input  logic             s_last_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [47:0]      m_data_o,
    output logic [CNT_W-1:0] m_count_o,
    output logic             m_carry_o,
    output logic [17:0]      DSP_A_o,
    output logic [17:0]      DSP_B_o,
    output logic [17:0]      DSP_D_o,
    output logic [47:0]      DSP_C_o,
    output logic [7:0]       DSP_OPMODE_o,
    output logic             DSP_CEA_o,
    output logic             DSP_CEB_o,
    output logic             DSP_CED_o,
    output logic             DSP_CEC_o,
    output logic             DSP_CEM_o,
    output logic             DSP_CEOPMODE_o,
    output logic             DSP_CECARRYIN_o,
    output logic             DSP_CEP_o,
    output logic             DSP_RSTA_o,
    output logic             DSP_RSTB_o,
    output logic             DSP_RSTC_o,
    output logic             DSP_RSTD_o,
    output logic             DSP_RSTM_o,
    output logic             DSP_RSTOPMODE_o,
    output logic             DSP_RSTCARRYIN_o,
    output logic             DSP_RSTP_o,
    input  logic [47:0]      DSP_P_i,
    input  logic             DSP_CARRYOUT_i
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

`ifdef SEQ_PREADD_EN
    localparam logic [7:0] OPM_PRE = 8'b0001_0000;
`else
    localparam logic [7:0] OPM_PRE = 8'b0000_0000;
`endif
    localparam logic [7:0] OPM_FIRST = 8'b0000_0001 | OPM_PRE;
    localparam logic [7:0] OPM_ACC   = 8'b0000_1001 | OPM_PRE;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              rstCycle_q;
    logic [17:0]       dspA_q, dspB_q, dspD_q;
    logic [7:0]        opmode_q;
    tag_t              tagPipe_q [0:DSP_LAT];
    logic [CNT_W-1:0]  beatCnt_q;
    logic              carryAcc_q;
    logic [47:0]       mData_q;
    logic [CNT_W-1:0]  mCount_q;
    logic              mCarry_q;
    logic              acceptBeat;
    logic              firstBeat;
    logic              capture;
    logic              carryNext;
    logic              ceOn;

    // Handshake and state sequencing. s_ready stays low during the cycle
    // that follows a reset edge so no beat lands while the slice clears.
    always_comb begin
        state_d    = state_q;
        s_ready_o  = 1'b0;
        m_valid_o  = 1'b0;
        acceptBeat = 1'b0;
        capture    = 1'b0;
        firstBeat  = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                s_ready_o  = !rstCycle_q;
                acceptBeat = s_valid_i && s_ready_o;
                if (acceptBeat) begin
                    state_d = s_last_i ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                s_ready_o  = 1'b1;
                acceptBeat = s_valid_i;
                if (acceptBeat && s_last_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tagPipe_q[DSP_LAT].valid && tagPipe_q[DSP_LAT].last) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The tag at the last stage marks the cycle right after P was written,
    // so DSP_CARRYOUT then belongs to that beat. A first beat restarts the
    // sticky carry for the new vector.
    always_comb begin
        carryNext = carryAcc_q | DSP_CARRYOUT_i;
        if (tagPipe_q[DSP_LAT].first) begin
            carryNext = DSP_CARRYOUT_i;
        end
    end

    // State, operand registers, tag pipeline and result capture. OPMODE is
    // written on the edge where a tag enters stage OPM_DLY, so the slice
    // OPMODE register lines up with M at the post-adder.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            rstCycle_q <= 1'b1;
            dspA_q     <= '0;
            dspB_q     <= '0;
            dspD_q     <= '0;
            opmode_q   <= '0;
            for (int s = 0; s <= DSP_LAT; s++) begin
                tagPipe_q[s] <= '0;
            end
            beatCnt_q  <= '0;
            carryAcc_q <= 1'b0;
            mData_q    <= '0;
            mCount_q   <= '0;
            mCarry_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rstCycle_q <= 1'b0;
            if (acceptBeat) begin
                dspA_q <= s_a_i;
                dspB_q <= s_b_i;
`ifdef SEQ_PREADD_EN
                dspD_q <= s_d_i;
`else
                dspD_q <= '0;
`endif
                if (firstBeat) begin
                    beatCnt_q <= CNT_ONE;
                end else if (!(&beatCnt_q)) begin
                    beatCnt_q <= beatCnt_q + CNT_ONE;
                end
            end
            tagPipe_q[0] <= acceptBeat ? {1'b1, firstBeat, s_last_i} : 3'b000;
            for (int s = 1; s <= DSP_LAT; s++) begin
                tagPipe_q[s] <= tagPipe_q[s-1];
            end
            if (tagPipe_q[OPM_DLY-1].valid) begin
                opmode_q <= tagPipe_q[OPM_DLY-1].first ? OPM_FIRST : OPM_ACC;
            end
            if (tagPipe_q[DSP_LAT].valid) begin
                carryAcc_q <= carryNext;
            end
            if (capture) begin
                mData_q  <= DSP_P_i;
                mCount_q <= beatCnt_q;
                mCarry_q <= carryNext;
            end
        end
    end

    assign ceOn = !rstCycle_q;

    assign m_data_o  = mData_q;
    assign m_count_o = mCount_q;
    assign m_carry_o = mCarry_q;

    assign DSP_A_o      = dspA_q;
    assign DSP_B_o      = dspB_q;
    assign DSP_D_o      = dspD_q;
    assign DSP_C_o      = '0;
    assign DSP_OPMODE_o = opmode_q;

    assign DSP_CEA_o       = ceOn;
    assign DSP_CEB_o       = ceOn;
    assign DSP_CED_o       = ceOn;
    assign DSP_CEC_o       = 1'b0;
    assign DSP_CEM_o       = ceOn;
    assign DSP_CEOPMODE_o  = ceOn;
    assign DSP_CECARRYIN_o = 1'b0;
    // P only loads for a real beat, so bubbles never fold stale M into P.
    assign DSP_CEP_o       = ceOn && tagPipe_q[DSP_LAT-1].valid;

    assign DSP_RSTA_o       = rstCycle_q;
    assign DSP_RSTB_o       = rstCycle_q;
    assign DSP_RSTC_o       = rstCycle_q;
    assign DSP_RSTD_o       = rstCycle_q;
    assign DSP_RSTM_o       = rstCycle_q;
    assign DSP_RSTOPMODE_o  = rstCycle_q;
    assign DSP_RSTCARRYIN_o = rstCycle_q;
    assign DSP_RSTP_o       = rstCycle_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// ============================================================================
// tb_dsp_mac_sequencer
// ----------------------------------------------------------------------------
// Drives dsp_mac_sequencer against a behavioural DSP48A1 slice subset.
// Expected results are computed as plain dot products from the beat lists
// and queued. A monitor compares every presented result with the queue head.
// ============================================================================
module tb_dsp_mac_sequencer;

    localparam int DSP_LAT = 4;
    localparam int CNT_W   = 16;

    typedef struct {
        logic [47:0] data;
        logic [15:0] count;
        logic        carry;
        time         acceptT;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid, s_ready, s_last;
    logic [17:0]       s_a, s_b, s_d;
    logic              m_valid, m_ready, m_carry;
    logic [47:0]       m_data;
    logic [CNT_W-1:0]  m_count;
    logic [17:0]       DSP_A, DSP_B, DSP_D;
    logic [47:0]       DSP_C, DSP_P;
    logic [7:0]        DSP_OPMODE;
    logic DSP_CEA, DSP_CEB, DSP_CED, DSP_CEC, DSP_CEM, DSP_CEOPMODE, DSP_CECARRYIN, DSP_CEP;
    logic DSP_RSTA, DSP_RSTB, DSP_RSTC, DSP_RSTD, DSP_RSTM, DSP_RSTOPMODE, DSP_RSTCARRYIN, DSP_RSTP;
    logic DSP_CARRYOUT;

    exp_t                expQ[$];
    logic signed [17:0]  beatA[$];
    logic signed [17:0]  beatB[$];
    logic signed [17:0]  beatD[$];
    int                  passCount = 0;
    int                  totalCount = 0;
    int                  cepPulses = 0;
    bit                  inFlight = 0;
    bit                  holdReady = 0;
    bit                  prevValid = 0;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.DSP_LAT(DSP_LAT), .OPM_DLY(2), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_a_i(s_a), .s_b_i(s_b),
`ifdef SEQ_PREADD_EN
        .s_d_i(s_d),
`endif
        .s_last_i(s_last),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .m_count_o(m_count), .m_carry_o(m_carry),
        .DSP_A_o(DSP_A), .DSP_B_o(DSP_B), .DSP_D_o(DSP_D), .DSP_C_o(DSP_C),
        .DSP_OPMODE_o(DSP_OPMODE),
        .DSP_CEA_o(DSP_CEA), .DSP_CEB_o(DSP_CEB), .DSP_CED_o(DSP_CED), .DSP_CEC_o(DSP_CEC),
        .DSP_CEM_o(DSP_CEM), .DSP_CEOPMODE_o(DSP_CEOPMODE), .DSP_CECARRYIN_o(DSP_CECARRYIN),
        .DSP_CEP_o(DSP_CEP),
        .DSP_RSTA_o(DSP_RSTA), .DSP_RSTB_o(DSP_RSTB), .DSP_RSTC_o(DSP_RSTC), .DSP_RSTD_o(DSP_RSTD),
        .DSP_RSTM_o(DSP_RSTM), .DSP_RSTOPMODE_o(DSP_RSTOPMODE),
        .DSP_RSTCARRYIN_o(DSP_RSTCARRYIN), .DSP_RSTP_o(DSP_RSTP),
        .DSP_P_i(DSP_P), .DSP_CARRYOUT_i(DSP_CARRYOUT)
    );

    // Behavioural DSP48A1 subset: A0/A1, B0/B1 with pre-adder on D0, M,
    // OPMODE register, and P with registered carry out of the post-adder.
    logic signed [17:0] slA0, slA1, slB0, slB1, slD0;
    logic signed [35:0] slM;
    logic [47:0]        slP, xSel, zSel;
    logic [7:0]         slOpm;
    logic               slCarry;

    assign xSel = (slOpm[1:0] == 2'b01) ? {{12{slM[35]}}, slM} : 48'd0;
    assign zSel = (slOpm[3:2] == 2'b10) ? slP : 48'd0;
    assign DSP_P = slP;
    assign DSP_CARRYOUT = slCarry;

    always @(posedge clk) begin
        if (DSP_RSTA) begin slA0 <= '0; slA1 <= '0; end
        else if (DSP_CEA) begin slA0 <= DSP_A; slA1 <= slA0; end
        if (DSP_RSTB) begin slB0 <= '0; slB1 <= '0; end
        else if (DSP_CEB) begin slB0 <= DSP_B; slB1 <= slB0 + slD0; end
        if (DSP_RSTD) slD0 <= '0;
        else if (DSP_CED) slD0 <= DSP_D;
        if (DSP_RSTM) slM <= '0;
        else if (DSP_CEM) slM <= slA1 * slB1;
        if (DSP_RSTOPMODE) slOpm <= '0;
        else if (DSP_CEOPMODE) slOpm <= DSP_OPMODE;
        if (DSP_RSTP) {slCarry, slP} <= '0;
        else if (DSP_CEP) {slCarry, slP} <= {1'b0, zSel} + {1'b0, xSel};
    end

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        totalCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Reference dot product straight from the beat lists.
    function automatic exp_t modelVector();
        exp_t               e;
        logic signed [63:0] sum = 0;
        logic signed [63:0] prod;
        logic signed [17:0] bd;
        logic [48:0]        wide;
        bit                 cy = 0;
        for (int i = 0; i < beatA.size(); i++) begin
            bd   = beatB[i] + beatD[i];
            prod = 64'(beatA[i]) * 64'(bd);
            if (i > 0) begin
                wide = {1'b0, sum[47:0]} + {1'b0, prod[47:0]};
                cy   = cy | wide[48];
            end
            sum = sum + prod;
        end
        e.data    = sum[47:0];
        e.count   = (beatA.size() > 65535) ? 16'hFFFF : 16'(beatA.size());
        e.carry   = cy;
        e.acceptT = 0;
        return e;
    endfunction

    // Sends the queued beats; gap < 0 picks a random 0..2 idle gap per beat.
    task automatic applyStimulus(input int gap, input bit withLast);
        int   n;
        int   g;
        int   guard;
        bit   got;
        exp_t e;
        n = beatA.size();
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_a     = beatA[i];
            s_b     = beatB[i];
            s_d     = beatD[i];
            s_last  = withLast && (i == n - 1);
            got = 0;
            guard = 0;
            while (!got && guard < 200) begin
                @(negedge clk);
                got = s_ready;
                @(posedge clk);
                guard++;
            end
            if (!got) checkOutput("accept_timeout", 0, 1);
            if (got && s_last) begin
                e = modelVector();
                e.acceptT = $time;
                expQ.push_back(e);
                inFlight = 1;
            end
            #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_a     = 18'($urandom);
            s_b     = 18'($urandom);
            s_d     = 18'($urandom);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (i < n - 1) repeat (g) begin @(posedge clk); #1; end
        end
    endtask

    task automatic loadBeat(input int a, input int b, input int d);
        beatA.push_back(18'(a));
        beatB.push_back(18'(b));
`ifdef SEQ_PREADD_EN
        beatD.push_back(18'(d));
`else
        beatD.push_back(18'(0 * d));
`endif
    endtask

    task automatic clearBeats();
        beatA.delete();
        beatB.delete();
        beatD.delete();
    endtask

    task automatic waitDrain(input string name);
        int guard = 0;
        while (expQ.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput(name, expQ.size(), 0);
        @(posedge clk); #1;
    endtask

    // Ready pattern: random back-pressure unless a test forces it low.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_ready = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every presented result with the scoreboard head,
    // every cycle it is valid, and checks s_ready is low while one is owed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (DSP_CEP) cepPulses++;
            if (inFlight) checkOutput("s_ready_low_in_flight", s_ready, 0);
            if (m_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_m_valid", m_valid, 0);
                end else begin
                    if (!prevValid)
                        checkOutput("latency", longint'(($time - 5 - expQ[0].acceptT) / 10), DSP_LAT + 1);
                    checkOutput("m_data", m_data, expQ[0].data);
                    checkOutput("m_count", m_count, expQ[0].count);
                    checkOutput("m_carry", m_carry, expQ[0].carry);
                    if (m_ready) begin
                        void'(expQ.pop_front());
                        inFlight = 0;
                    end
                end
            end
            prevValid = m_valid;
        end else begin
            prevValid = 0;
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_a = '0; s_b = '0; s_d = '0;

        // Reset with random stimulus on the inputs.
        repeat (3) begin
            @(posedge clk); #1;
            s_valid = 1'($urandom); s_last = 1'($urandom);
            s_a = 18'($urandom); s_b = 18'($urandom); s_d = 18'($urandom);
        end
        @(negedge clk);
        checkOutput("rst_dsp_rst", {DSP_RSTA, DSP_RSTB, DSP_RSTC, DSP_RSTD,
                    DSP_RSTM, DSP_RSTOPMODE, DSP_RSTCARRYIN, DSP_RSTP}, 8'hFF);
        checkOutput("rst_dsp_ce", {DSP_CEA, DSP_CEB, DSP_CED, DSP_CEC,
                    DSP_CEM, DSP_CEOPMODE, DSP_CECARRYIN, DSP_CEP}, 8'h00);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_m_count", m_count, 0);
        checkOutput("rst_m_carry", m_carry, 0);
        checkOutput("rst_dsp_ab_opm", {DSP_A, DSP_B, DSP_D, DSP_OPMODE}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_s_ready", s_ready, 1);
        checkOutput("idle_dsp_rst", {DSP_RSTA, DSP_RSTB, DSP_RSTC, DSP_RSTD,
                    DSP_RSTM, DSP_RSTOPMODE, DSP_RSTCARRYIN, DSP_RSTP}, 8'h00);
        checkOutput("idle_dsp_ce", {DSP_CEA, DSP_CEB, DSP_CED, DSP_CEC,
                    DSP_CEM, DSP_CEOPMODE, DSP_CECARRYIN, DSP_CEP}, 8'b1110_1100);
        @(posedge clk); #1;

        // Single beat 20*10.
        clearBeats(); loadBeat(20, 10, 0);
        applyStimulus(0, 1);
        waitDrain("drain_single");

        // Back-to-back 3-beat vector.
        clearBeats(); loadBeat(3, 4, 0); loadBeat(5, 6, 0); loadBeat(7, 8, 0);
        applyStimulus(0, 1);
        waitDrain("drain_b2b");

        // Same vector with 2 idle cycles between beats; P loads once per beat.
        cepPulses = 0;
        applyStimulus(2, 1);
        waitDrain("drain_gap");
        checkOutput("cep_pulses", cepPulses, 3);

        // Signed vector with m_ready held low while the result is presented.
        holdReady = 1;
        clearBeats(); loadBeat(-2, 3, 0); loadBeat(1, 1, 0);
        applyStimulus(0, 1);
        guard = 0;
        while (!m_valid && guard < 50) begin @(negedge clk); guard++; end
        checkOutput("hold_wait_valid", m_valid, 1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_valid", m_valid, 1);
        end
        @(posedge clk); #1;
        holdReady = 0;
        waitDrain("drain_hold");
        clearBeats(); loadBeat(2, 2, 0);
        applyStimulus(0, 1);
        waitDrain("drain_after_hold");

        // Reset after two beats of a vector, then a fresh single-beat vector.
        clearBeats(); loadBeat(9, 9, 0); loadBeat(11, -7, 0);
        applyStimulus(0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            s_valid = 1'($urandom); s_a = 18'($urandom); s_b = 18'($urandom);
        end
        rst_n = 1'b1; s_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        clearBeats(); loadBeat(4, 5, 25);
        applyStimulus(0, 1);
        waitDrain("drain_after_abort");

        // Randomized vectors with random gaps and back-pressure.
        for (int v = 0; v < 25; v++) begin
            int n;
            n = int'($urandom_range(1, 6));
            clearBeats();
            for (int i = 0; i < n; i++) loadBeat(int'($urandom), int'($urandom), int'($urandom));
            applyStimulus(-1, 1);
        end
        waitDrain("drain_random");

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
